// File: rtl/dcache_refill.sv
// ============================================================================
// dcache_refill : D-cache miss handler (victim write-back, line fetch, refill)
// Rev 1.0
// ============================================================================
`default_nettype none

module dcache_refill #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int BEATS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_i,
  input  logic              write_back_i,
  input  logic              lru_i,
  input  logic [ADDR_W-1:0] miss_addr_i,
  input  logic [ADDR_W-1:0] victim_addr_i,
  input  logic [DATA_W-1:0] victim_data_i,
  output logic              vic_way_o,
  output logic [((BEATS > 1) ? $clog2(BEATS) : 1)-1:0] vic_beat_o,
  output logic              refill_we_o,
  output logic              refill_way_o,
  output logic [((BEATS > 1) ? $clog2(BEATS) : 1)-1:0] refill_beat_o,
  output logic [DATA_W-1:0] refill_data_o,
  output logic              refresh_o,
  output logic              stallreq_o,
  output logic              err_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic              mem_req_we_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic              mem_wvalid_o,
  input  logic              mem_wready_i,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_wlast_o,
  input  logic              mem_bvalid_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_rlast_i
);

  localparam int C_BW  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int C_OFF = $clog2(DATA_W / 8 * BEATS);
  localparam logic [C_BW-1:0]   C_LAST  = C_BW'(BEATS - 1);
  localparam logic [C_BW-1:0]   C_ONE   = C_BW'(1);
  localparam logic [ADDR_W-1:0] C_ALIGN = ~((ADDR_W'(1) << C_OFF) - ADDR_W'(1));

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WB_ADDR = 3'd1,
    S_WB_DATA = 3'd2,
    S_WB_RESP = 3'd3,
    S_RD_ADDR = 3'd4,
    S_RD_DATA = 3'd5,
    S_REFILL  = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [C_BW-1:0]   beat_q, beat_d;
  logic              way_q, way_d;
  logic [ADDR_W-1:0] vaddr_q, vaddr_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic              err_q, err_d;
  logic              last_beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      way_q   <= 1'b0;
      vaddr_q <= '0;
      maddr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      way_q   <= way_d;
      vaddr_q <= vaddr_d;
      maddr_q <= maddr_d;
      err_q   <= err_d;
    end
  end

  assign last_beat = (beat_q == C_LAST);

  always_comb begin
    state_d         = state_q;
    beat_d          = beat_q;
    way_d           = way_q;
    vaddr_d         = vaddr_q;
    maddr_d         = maddr_q;
    err_d           = err_q;
    refill_we_o     = 1'b0;
    refill_data_o   = '0;
    refresh_o       = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_req_we_o    = 1'b0;
    mem_req_addr_o  = '0;
    mem_wvalid_o    = 1'b0;
    mem_wdata_o     = '0;
    mem_wlast_o     = 1'b0;

    // Responses arriving in the wrong phase are flagged but otherwise dropped.
    if (mem_bvalid_i && (state_q != S_WB_RESP)) err_d = 1'b1;
    if (mem_rvalid_i && (state_q != S_RD_DATA)) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (miss_i) begin
          way_d   = lru_i;
          vaddr_d = victim_addr_i;
          maddr_d = miss_addr_i & C_ALIGN;
          state_d = write_back_i ? S_WB_ADDR : S_RD_ADDR;
        end
      end
      S_WB_ADDR: begin
        mem_req_valid_o = 1'b1;
        mem_req_we_o    = 1'b1;
        mem_req_addr_o  = vaddr_q;
        if (mem_req_ready_i) begin
          beat_d  = '0;
          state_d = S_WB_DATA;
        end
      end
      S_WB_DATA: begin
        mem_wvalid_o = 1'b1;
        mem_wdata_o  = victim_data_i;
        mem_wlast_o  = last_beat;
        if (mem_wready_i) begin
          if (last_beat) begin
            beat_d  = '0;
            state_d = S_WB_RESP;
          end else begin
            beat_d = beat_q + C_ONE;
          end
        end
      end
      S_WB_RESP: begin
        if (mem_bvalid_i) state_d = S_RD_ADDR;
      end
      S_RD_ADDR: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = maddr_q;
        if (mem_req_ready_i) begin
          beat_d  = '0;
          state_d = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (mem_rvalid_i) begin
          refill_we_o   = 1'b1;
          refill_data_o = mem_rdata_i;
          // Completion is by beat count; rlast is only a consistency check.
          if (mem_rlast_i != last_beat) err_d = 1'b1;
          if (last_beat) begin
            beat_d  = '0;
            state_d = S_REFILL;
          end else begin
            beat_d = beat_q + C_ONE;
          end
        end
      end
      S_REFILL: begin
        refresh_o = 1'b1;
        state_d   = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign vic_way_o     = way_q;
  assign vic_beat_o    = beat_q;
  assign refill_way_o  = way_q;
  assign refill_beat_o = beat_q;
  assign err_o         = err_q;
  assign stallreq_o    = ~rst & (((state_q == S_IDLE) & miss_i) |
                                 ((state_q != S_IDLE) & (state_q != S_DONE)));

endmodule

`default_nettype wire
